// File: rtl/pdm_pkg.sv
// Shared types and helpers for the multi-channel pulse-density modulator.
// The mode enum matches the single run-time mode input bit.
package pdm_pkg;

    typedef enum logic {
        PDM_SD  = 1'b0,
        PDM_PWM = 1'b1
    } pdm_mode_e;

    // Modulation period in clock cycles for a given setpoint width.
    function automatic int pdm_period(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/pdm_channel.sv
// One modulator channel: shadow/active setpoint pair, sigma-delta accumulator
// and the registered output bit.
module pdm_channel
    import pdm_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] cnt,
    input  logic             boundary,
    input  logic             transfer,
    input  pdm_mode_e        mode_q,
    output logic             pdm_out
);

    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] active_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             out_reg;
    logic [WIDTH:0]   sum_next;

    always_comb begin
        sum_next = {1'b0, acc_reg} + {1'b0, active_reg};
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            shadow_reg <= '0;
            active_reg <= '0;
            acc_reg    <= '0;
            out_reg    <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow_reg <= wr_data;
            end
            // Reads the pre-edge shadow, so a same-edge write waits for the next commit.
            if (boundary && transfer) begin
                active_reg <= shadow_reg;
            end
            if (mode_q == PDM_SD) begin
                acc_reg <= sum_next[WIDTH-1:0];
                out_reg <= sum_next[WIDTH];
            end else begin
                out_reg <= (cnt < active_reg);
            end
        end
    end

    assign pdm_out = out_reg;

endmodule

// File: rtl/pdm_array.sv
// Multi-channel PDM/PWM generator with shadowed setpoints that all switch
// together on the period boundary.
module pdm_array
    import pdm_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    localparam int AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                commit,
    input  logic                mode,
    output logic                commit_pending,
    output logic [CHANNELS-1:0] pdm_out
);

    localparam int P = pdm_period(WIDTH);

    logic [WIDTH-1:0]    cnt_reg;
    logic                pend_reg;
    pdm_mode_e           mode_q_reg;
    logic                boundary;
    logic                transfer;
    logic [CHANNELS-1:0] wr_sel;

    assign boundary = (cnt_reg == WIDTH'(P - 1));
    // A commit landing on the boundary cycle is honoured without going pending.
    assign transfer = pend_reg | commit;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_reg    <= '0;
            pend_reg   <= 1'b0;
            mode_q_reg <= PDM_SD;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (boundary) begin
                pend_reg   <= 1'b0;
                mode_q_reg <= pdm_mode_e'(mode);
            end else if (commit) begin
                pend_reg <= 1'b1;
            end
        end
    end

    assign commit_pending = pend_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            // Addresses at or above CHANNELS match no channel and are dropped.
            assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));

            pdm_channel #(
                .WIDTH(WIDTH)
            ) u_ch (
                .Clock    (Clock),
                .nReset   (nReset),
                .wr_en    (wr_sel[gi]),
                .wr_data  (wr_data),
                .cnt      (cnt_reg),
                .boundary (boundary),
                .transfer (transfer),
                .mode_q   (mode_q_reg),
                .pdm_out  (pdm_out[gi])
            );
        end
    endgenerate

endmodule
